// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with a 256x8 data memory and registered MEM/WB outputs

module mem_stage #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             reg_write_in,
    input  logic             mem_to_reg_in,
    input  logic [7:0]       ALUResult_in,
    input  logic [7:0]       RdVal_in,
    input  logic [2:0]       Rd_in,
    output logic             stall_out,
    output logic             fwd_valid_out,
    output logic [7:0]       fwd_data_out,
    output logic             reg_write_out,
    output logic [7:0]       wb_data_out,
    output logic [2:0]       Rd_out,
    output logic             conflict_out,
    output logic [CNT_W-1:0] load_count_out,
    output logic [CNT_W-1:0] store_count_out
);

    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t     state, next_state;
    logic [7:0] addr_q;
    logic [2:0] rd_q;
    logic [7:0] mem [DEPTH];

    logic       mem_we;
    logic       accept_load;
    logic       load_done;
    logic       store_done;
    logic       conflict_set;
    logic       rw_d;
    logic [7:0] wb_d;
    logic [2:0] rd_d;

    always_comb begin
        next_state   = state;
        stall_out    = 1'b0;
        mem_we       = 1'b0;
        accept_load  = 1'b0;
        load_done    = 1'b0;
        store_done   = 1'b0;
        conflict_set = 1'b0;
        rw_d         = reg_write_in;
        wb_d         = ALUResult_in;
        rd_d         = Rd_in;
        case (state)
            IDLE: begin
                if (mem_write_in) begin
                    // A simultaneous read request is dropped and flagged.
                    mem_we       = 1'b1;
                    store_done   = 1'b1;
                    conflict_set = mem_read_in;
                end else if (mem_read_in) begin
                    stall_out   = 1'b1;
                    accept_load = 1'b1;
                    next_state  = LOAD;
                    rw_d        = 1'b0;
                    wb_d        = 8'h00;
                    rd_d        = 3'd0;
                end
            end
            LOAD: begin
                // Inputs are the held load instruction here and are ignored.
                rw_d       = 1'b1;
                wb_d       = mem[addr_q];
                rd_d       = rd_q;
                load_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            stall_out = 1'b0;
            mem_we    = 1'b0;
        end
    end

    assign fwd_valid_out = reg_write_in & ~mem_to_reg_in & (state == IDLE) & ~reset;
    assign fwd_data_out  = ALUResult_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            addr_q          <= 8'h00;
            rd_q            <= 3'd0;
            reg_write_out   <= 1'b0;
            wb_data_out     <= 8'h00;
            Rd_out          <= 3'd0;
            conflict_out    <= 1'b0;
            load_count_out  <= '0;
            store_count_out <= '0;
        end else begin
            state         <= next_state;
            reg_write_out <= rw_d;
            wb_data_out   <= wb_d;
            Rd_out        <= rd_d;
            if (accept_load) begin
                addr_q <= ALUResult_in;
                rd_q   <= Rd_in;
            end
            if (conflict_set) begin
                conflict_out <= 1'b1;
            end
            if (load_done && (load_count_out != '1)) begin
                load_count_out <= load_count_out + CNT_ONE;
            end
            if (store_done && (store_count_out != '1)) begin
                store_count_out <= store_count_out + CNT_ONE;
            end
        end
    end

    // Array has no reset so its contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ALUResult_in] <= RdVal_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage

module tb_mem_stage;

    typedef struct packed {
        logic       rw;
        logic [7:0] data;
        logic [2:0] rd;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic [7:0]  ALUResult_in, RdVal_in;
    logic [2:0]  Rd_in;
    logic        stall_out, fwd_valid_out, reg_write_out, conflict_out;
    logic [7:0]  fwd_data_out, wb_data_out;
    logic [2:0]  Rd_out;
    logic [15:0] load_count_out, store_count_out;

    int  vectors = 0;
    int  miscompares = 0;
    wb_t sb[$];

    mem_stage #(.DEPTH(256), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .ALUResult_in(ALUResult_in), .RdVal_in(RdVal_in), .Rd_in(Rd_in),
        .stall_out(stall_out), .fwd_valid_out(fwd_valid_out), .fwd_data_out(fwd_data_out),
        .reg_write_out(reg_write_out), .wb_data_out(wb_data_out), .Rd_out(Rd_out),
        .conflict_out(conflict_out), .load_count_out(load_count_out),
        .store_count_out(store_count_out)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic rd_i, input logic wr_i, input logic rw_i, input logic m2r_i,
                         input logic [7:0] alu_i, input logic [7:0] data_i, input logic [2:0] rdst_i,
                         output logic stall_s, output logic fwd_s);
        mem_read_in   = rd_i;
        mem_write_in  = wr_i;
        reg_write_in  = rw_i;
        mem_to_reg_in = m2r_i;
        ALUResult_in  = alu_i;
        RdVal_in      = data_i;
        Rd_in         = rdst_i;
        #1;
        stall_s = stall_out;
        fwd_s   = fwd_valid_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic st, fw;
        reset = 1'b1;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00, 3'd4, st, fw);
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", st); end
        vectors++; if (fw !== 1'b0) begin miscompares++; $display("FAIL reset_fwd got %b exp 0", fw); end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, st, fw);
        reset = 1'b0;
        #1;
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== 12'h000) begin
            miscompares++; $display("FAIL reset_wb got %b/%h/%0d exp 0/00/0", reg_write_out, wb_data_out, Rd_out); end
        vectors++; if ({load_count_out, store_count_out, conflict_out, stall_out} !== 34'd0) begin
            miscompares++; $display("FAIL reset_state got lc=%h sc=%h cf=%b st=%b exp all 0",
                                    load_count_out, store_count_out, conflict_out, stall_out); end
    endtask

    task automatic test_alu();
        logic st, fw;
        wb_t  e;
        logic       rw_t  [3] = '{1'b1, 1'b1, 1'b0};
        logic       m2r_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] alu_t [3] = '{8'h5A, 8'hA5, 8'h33};
        logic [2:0] rd_t  [3] = '{3'd3, 3'd6, 3'd2};
        logic       fwd_t [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{rw: rw_t[i], data: alu_t[i], rd: rd_t[i]});
            apply(1'b0, 1'b0, rw_t[i], m2r_t[i], alu_t[i], 8'hEE, rd_t[i], st, fw);
            vectors++; if (fw !== fwd_t[i]) begin miscompares++; $display("FAIL alu_fwd[%0d] got %b exp %b", i, fw, fwd_t[i]); end
            vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL alu_stall[%0d] got %b exp 0", i, st); end
            e = sb.pop_front();
            vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
                miscompares++; $display("FAIL alu_wb[%0d] got %b/%h/%0d exp %b/%h/%0d", i,
                                        reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        end
    endtask

    task automatic test_store_load();
        logic st, fw;
        wb_t  e;
        sb.push_back('{rw: 1'b0, data: 8'h10, rd: 3'd0});
        apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'hC3, 3'd0, st, fw);
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL store_stall got %b exp 0", st); end
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL store_wb got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        sb.push_back('{rw: 1'b0, data: 8'h00, rd: 3'd0});
        apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 3'd5, st, fw);
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL load_accept_stall got %b exp 1", st); end
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL load_bubble got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        sb.push_back('{rw: 1'b1, data: 8'hC3, rd: 3'd5});
        apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 3'd5, st, fw);
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL load_second_stall got %b exp 0", st); end
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL load_wb got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        vectors++; if (load_count_out !== 16'd1 || store_count_out !== 16'd1) begin
            miscompares++; $display("FAIL store_load_counts got lc=%0d sc=%0d exp 1/1", load_count_out, store_count_out); end
    endtask

    task automatic test_back_to_back();
        logic st, fw;
        wb_t  e;
        logic [7:0] addr_t [2] = '{8'h00, 8'hFF};
        logic [7:0] dat_t  [2] = '{8'h11, 8'h22};
        logic       stall_exp [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{rw: 1'b0, data: addr_t[i], rd: 3'd0});
            apply(1'b0, 1'b1, 1'b0, 1'b0, addr_t[i], dat_t[i], 3'd0, st, fw);
            e = sb.pop_front();
            vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
                miscompares++; $display("FAIL b2b_store_wb[%0d] got %b/%h/%0d exp %b/%h/%0d", i, reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        end
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (c == 0) sb.push_back('{rw: 1'b0, data: 8'h00, rd: 3'd0});
                else        sb.push_back('{rw: 1'b1, data: dat_t[i], rd: 3'(i + 1)});
                apply(1'b1, 1'b0, 1'b1, 1'b1, addr_t[i], 8'h00, 3'(i + 1), st, fw);
                vectors++; if (st !== stall_exp[c]) begin
                    miscompares++; $display("FAIL b2b_stall[%0d.%0d] got %b exp %b", i, c, st, stall_exp[c]); end
                e = sb.pop_front();
                vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
                    miscompares++; $display("FAIL b2b_wb[%0d.%0d] got %b/%h/%0d exp %b/%h/%0d", i, c, reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
            end
        end
        vectors++; if (load_count_out !== 16'd3 || store_count_out !== 16'd3) begin
            miscompares++; $display("FAIL b2b_counts got lc=%0d sc=%0d exp 3/3", load_count_out, store_count_out); end
    endtask

    task automatic test_conflict();
        logic st, fw;
        wb_t  e;
        sb.push_back('{rw: 1'b0, data: 8'h20, rd: 3'd0});
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h7E, 3'd0, st, fw);
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL conflict_stall got %b exp 0", st); end
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL conflict_wb got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        vectors++; if (conflict_out !== 1'b1 || store_count_out !== 16'd4) begin
            miscompares++; $display("FAIL conflict_flag got cf=%b sc=%0d exp 1/4", conflict_out, store_count_out); end
        sb.push_back('{rw: 1'b0, data: 8'h00, rd: 3'd0});
        sb.push_back('{rw: 1'b1, data: 8'h7E, rd: 3'd4});
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 8'h00, 3'd4, st, fw);
            e = sb.pop_front();
            vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
                miscompares++; $display("FAIL conflict_load_wb[%0d] got %b/%h/%0d exp %b/%h/%0d", c, reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        end
        sb.push_back('{rw: 1'b1, data: 8'h01, rd: 3'd1});
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 3'd1, st, fw);
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL conflict_alu_wb got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        vectors++; if (conflict_out !== 1'b1 || load_count_out !== 16'd4) begin
            miscompares++; $display("FAIL conflict_sticky got cf=%b lc=%0d exp 1/4", conflict_out, load_count_out); end
    endtask

    task automatic test_reset_in_load();
        logic st, fw;
        wb_t  e;
        sb.push_back('{rw: 1'b0, data: 8'h40, rd: 3'd0});
        apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h55, 3'd0, st, fw);
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL rl_store_wb got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 3'd7, st, fw);
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL rl_accept_stall got %b exp 1", st); end
        reset = 1'b1;
        sb.push_back('{rw: 1'b0, data: 8'h00, rd: 3'd0});
        apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 3'd7, st, fw);
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL rl_reset_stall got %b exp 0", st); end
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL rl_reset_wb got %b/%h/%0d exp 0/00/0", reg_write_out, wb_data_out, Rd_out); end
        vectors++; if (load_count_out !== 16'd0 || conflict_out !== 1'b0) begin
            miscompares++; $display("FAIL rl_reset_state got lc=%0d cf=%b exp 0/0", load_count_out, conflict_out); end
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h99, 3'd2, st, fw);
        reset = 1'b0;
        vectors++; if (store_count_out !== 16'd0) begin
            miscompares++; $display("FAIL rl_reset_store_count got %0d exp 0", store_count_out); end
        sb.push_back('{rw: 1'b0, data: 8'h00, rd: 3'd0});
        sb.push_back('{rw: 1'b1, data: 8'h55, rd: 3'd7});
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 3'd7, st, fw);
            if (c == 0) begin
                vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL rl_idle_accept got %b exp 1", st); end
            end
            e = sb.pop_front();
            vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
                miscompares++; $display("FAIL rl_reload_wb[%0d] got %b/%h/%0d exp %b/%h/%0d", c, reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        end
        sb.push_back('{rw: 1'b1, data: 8'hE7, rd: 3'd5});
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'hE7, 8'h00, 3'd5, st, fw);
        vectors++; if (fw !== 1'b1) begin miscompares++; $display("FAIL rl_alu_fwd got %b exp 1", fw); end
        e = sb.pop_front();
        vectors++; if ({reg_write_out, wb_data_out, Rd_out} !== e) begin
            miscompares++; $display("FAIL rl_alu_wb got %b/%h/%0d exp %b/%h/%0d", reg_write_out, wb_data_out, Rd_out, e.rw, e.data, e.rd); end
        vectors++; if (load_count_out !== 16'd1) begin
            miscompares++; $display("FAIL rl_load_count got %0d exp 1", load_count_out); end
    endtask

    task automatic test_saturation();
        logic st, fw;
        logic [15:0] exp_sc [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b1;
        reg_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        Rd_in         = 3'd0;
        for (int i = 0; i < 16'hFFFD; i++) begin
            ALUResult_in = 8'(i);
            RdVal_in     = 8'(i + 3);
            @(posedge clk);
        end
        #1;
        vectors++; if (store_count_out !== 16'hFFFD) begin
            miscompares++; $display("FAIL sat_base got %h exp fffd", store_count_out); end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 3'd0, st, fw);
            vectors++; if (store_count_out !== exp_sc[i]) begin
                miscompares++; $display("FAIL sat_store[%0d] got %h exp %h", i, store_count_out, exp_sc[i]); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
        ALUResult_in = 8'h00; RdVal_in = 8'h00; Rd_in = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_store_load();
        test_back_to_back();
        test_conflict();
        test_reset_in_load();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
